// File: rtl/axist_pkg.sv
// Shared definitions for the AXIST test-pattern blocks: state encoding,
// field widths and saturating-increment helpers.
package axist_pkg;

   localparam int AXIST_PAT_W = 40;
   localparam int CNT_W       = 16;
   localparam int ERR_W       = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } chk_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [CNT_W-1:0] IDX_NONE = {CNT_W{1'b1}};

   // Word counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   // Error counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
      if (v == ERR_MAX) begin
         return v;
      end else begin
         return v + ERR_W'(1);
      end
   endfunction

endpackage

// File: rtl/axist_chk_wdog.sv
// Idle watchdog for the pattern checker: a loadable down-counter that is
// reloaded on start/clear or on every received word, counts down on idle
// checking cycles, and pulses expire_o on the WDOG_CYC-th consecutive idle cycle.
module axist_chk_wdog #(
   parameter int WDOG_CYC = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic run_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int WD_W = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] RELOAD = WD_W'(WDOG_CYC);

   logic [WD_W-1:0] cnt_q;
   logic [WD_W-1:0] cnt_d;

   // Next count: reload on clear or activity, otherwise count idle cycles down.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || kick_i) begin
         cnt_d = RELOAD;
      end else if (run_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WD_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = run_i & ~kick_i & ~clr_i & (cnt_q == WD_W'(1));

endmodule

// File: rtl/axist_incr_chk.sv
// Receive-side checker for the AXIST incrementing test pattern. Compares each
// accepted word against seed, seed+1, ... and reports counts and pass/fail.
module axist_incr_chk
   import axist_pkg::*;
#(
   parameter int LEADER_MODE = 1,
   parameter int WDOG_CYC    = 1023
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               chk_start_i,
   input  logic [LEADER_MODE*AXIST_PAT_W-1:0] seed_in_i,
   input  logic [8:0]                         patgen_cnt_i,
   input  logic                               cntuspatt_en_i,
   input  logic                               data_vld_i,
   input  logic [LEADER_MODE*AXIST_PAT_W-1:0] data_in_i,
   output logic [LEADER_MODE*AXIST_PAT_W-1:0] exp_dout_o,
   output logic [CNT_W-1:0]                   rcv_cnt_o,
   output logic [ERR_W-1:0]                   err_cnt_o,
   output logic [CNT_W-1:0]                   first_err_idx_o,
   output logic                               chk_busy_o,
   output logic                               chk_done_o,
   output logic                               chk_pass_o,
   output logic                               timeout_o,
   output logic                               overrun_o
);

   localparam int W = LEADER_MODE * AXIST_PAT_W;

   chk_state_e       state_q, state_d;
   logic [W-1:0]     exp_q, exp_d;
   logic [CNT_W-1:0] rcv_q, rcv_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;
   logic             cont_q, cont_d;
   logic             en_r1_q;

   logic             in_check_s;
   logic             accept_s;
   logic             mismatch_s;
   logic             last_s;
   logic             fall_s;
   logic             wd_expire_s;
   logic             exit_s;
   logic [CNT_W-1:0] pcnt_ext_s;

   assign pcnt_ext_s  = {{(CNT_W-9){1'b0}}, patgen_cnt_i};
   assign in_check_s  = (state_q == ST_CHECK);
   // A start pulse wins over a word arriving in the same cycle.
   assign accept_s    = in_check_s & data_vld_i & ~chk_start_i;
   assign mismatch_s  = accept_s & (data_in_i != exp_q);
   assign last_s      = accept_s & ~cntuspatt_en_i & (rcv_q == pcnt_ext_s);
   assign fall_s      = en_r1_q & ~cntuspatt_en_i;
   assign exit_s      = in_check_s & ~chk_start_i & (last_s | fall_s | wd_expire_s);

   axist_chk_wdog #(
      .WDOG_CYC (WDOG_CYC)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (chk_start_i),
      .run_i    (in_check_s),
      .kick_i   (in_check_s & data_vld_i),
      .expire_o (wd_expire_s)
   );

   // Next-state logic: start always (re)enters CHECK; CHECK ends on terminal
   // count, enable falling edge or watchdog expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (chk_start_i) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (chk_start_i) begin
               state_d = ST_CHECK;
            end else if (exit_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_DONE: begin
            if (chk_start_i) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath next values: expected word, counters, first error index and sticky flags.
   always_comb begin
      exp_d     = exp_q;
      rcv_d     = rcv_q;
      err_d     = err_q;
      first_d   = first_q;
      timeout_d = timeout_q;
      overrun_d = overrun_q;
      cont_d    = cont_q;
      if (chk_start_i) begin
         exp_d     = seed_in_i;
         rcv_d     = '0;
         err_d     = '0;
         first_d   = IDX_NONE;
         timeout_d = 1'b0;
         overrun_d = 1'b0;
         cont_d    = 1'b0;
      end else begin
         if (accept_s) begin
            if (mismatch_s) begin
               err_d = sat_inc_err(err_q);
               if (err_q == '0) begin
                  first_d = rcv_q;
               end else begin
                  first_d = first_q;
               end
            end else begin
               err_d = err_q;
            end
            // The expected sequence free-runs; it never resyncs to received data.
            exp_d = exp_q + W'(1);
            rcv_d = sat_inc_cnt(rcv_q);
         end else begin
            exp_d = exp_q;
         end
         if (exit_s) begin
            // Remember whether the run ended as a continuous run for the pass verdict.
            cont_d    = fall_s;
            timeout_d = timeout_q | wd_expire_s;
         end else begin
            cont_d = cont_q;
         end
         if ((state_q == ST_DONE) && data_vld_i) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         exp_q     <= '0;
         rcv_q     <= '0;
         err_q     <= '0;
         first_q   <= IDX_NONE;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         cont_q    <= 1'b0;
         en_r1_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         rcv_q     <= rcv_d;
         err_q     <= err_d;
         first_q   <= first_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
         cont_q    <= cont_d;
         en_r1_q   <= cntuspatt_en_i;
      end
   end

   assign exp_dout_o      = exp_q;
   assign rcv_cnt_o       = rcv_q;
   assign err_cnt_o       = err_q;
   assign first_err_idx_o = first_q;
   assign chk_busy_o      = (state_q == ST_CHECK);
   assign chk_done_o      = (state_q == ST_DONE);
   assign timeout_o       = timeout_q;
   assign overrun_o       = overrun_q;
   assign chk_pass_o      = (state_q == ST_DONE) & (err_q == '0) & ~timeout_q & ~overrun_q &
                            (cont_q | (rcv_q == (pcnt_ext_s + CNT_W'(1))));

endmodule

// File: tb/tb_axist_incr_chk.sv
// Bench for axist_incr_chk: random and directed runs checked every cycle
// against a run-level model of the incrementing-pattern checker.
module tb_axist_incr_chk;

   localparam int W  = 40;
   localparam int WD = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          chk_start;
   logic [W-1:0]  seed_in;
   logic [8:0]    patgen_cnt;
   logic          cntuspatt_en;
   logic          data_vld;
   logic [W-1:0]  data_in;
   logic [W-1:0]  exp_dout;
   logic [15:0]   rcv_cnt;
   logic [8:0]    err_cnt;
   logic [15:0]   first_err_idx;
   logic          chk_busy;
   logic          chk_done;
   logic          chk_pass;
   logic          timeout;
   logic          overrun;

   always #5 clk = ~clk;

   axist_incr_chk #(.LEADER_MODE(1), .WDOG_CYC(WD)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .chk_start_i     (chk_start),
      .seed_in_i       (seed_in),
      .patgen_cnt_i    (patgen_cnt),
      .cntuspatt_en_i  (cntuspatt_en),
      .data_vld_i      (data_vld),
      .data_in_i       (data_in),
      .exp_dout_o      (exp_dout),
      .rcv_cnt_o       (rcv_cnt),
      .err_cnt_o       (err_cnt),
      .first_err_idx_o (first_err_idx),
      .chk_busy_o      (chk_busy),
      .chk_done_o      (chk_done),
      .chk_pass_o      (chk_pass),
      .timeout_o       (timeout),
      .overrun_o       (overrun)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: run phase (0 idle, 1 checking, 2 finished) and run results.
   int           m_phase, m_rcv, m_err, m_first, m_idle;
   bit           m_to, m_ov, m_cont, m_en_prev;
   logic [W-1:0] m_exp;

   logic [W-1:0] cur_seed;
   int           cur_pc;
   bit           cur_en;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_exp = '0; m_rcv = 0; m_err = 0; m_first = 16'hFFFF;
      m_idle = 0; m_to = 1'b0; m_ov = 1'b0; m_cont = 1'b0; m_en_prev = 1'b0;
   endtask

   // One clock of the checker's rules, applied to the inputs of that cycle.
   task automatic model_step(input bit st, input bit v, input logic [W-1:0] d, input bit en);
      bit fell, end_run;
      fell = m_en_prev && !en;
      end_run = 1'b0;
      if (st) begin
         m_phase = 1; m_exp = cur_seed; m_rcv = 0; m_err = 0; m_first = 16'hFFFF;
         m_idle = 0; m_to = 1'b0; m_ov = 1'b0; m_cont = 1'b0;
      end else if (m_phase == 1) begin
         if (v) begin
            if (d !== m_exp) begin
               if (m_err == 0) m_first = m_rcv;
               if (m_err < 511) m_err++;
            end
            if (!en && m_rcv == cur_pc) end_run = 1'b1;
            m_exp = m_exp + W'(1);
            if (m_rcv < 65535) m_rcv++;
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == WD) begin
               m_to = 1'b1;
               end_run = 1'b1;
            end
         end
         if (fell) end_run = 1'b1;
         if (end_run) begin
            m_phase = 2;
            m_cont = fell;
         end
      end else if (m_phase == 2 && v) begin
         m_ov = 1'b1;
      end
      m_en_prev = en;
   endtask

   task automatic compare_all();
      bit pass_e;
      pass_e = (m_phase == 2) && (m_err == 0) && !m_to && !m_ov && (m_cont || (m_rcv == cur_pc + 1));
      chk_val("exp_dout",      64'(exp_dout),      64'(m_exp));
      chk_val("rcv_cnt",       64'(rcv_cnt),       64'(m_rcv));
      chk_val("err_cnt",       64'(err_cnt),       64'(m_err));
      chk_val("first_err_idx", 64'(first_err_idx), 64'(m_first));
      chk_val("chk_busy",      64'(chk_busy),      64'(m_phase == 1));
      chk_val("chk_done",      64'(chk_done),      64'(m_phase == 2));
      chk_val("chk_pass",      64'(chk_pass),      64'(pass_e));
      chk_val("timeout",       64'(timeout),       64'(m_to));
      chk_val("overrun",       64'(overrun),       64'(m_ov));
   endtask

   task automatic step(input bit st, input bit v, input logic [W-1:0] d);
      @(negedge clk);
      chk_start = st; data_vld = v; data_in = d;
      cntuspatt_en = cur_en; patgen_cnt = 9'(cur_pc); seed_in = cur_seed;
      model_step(st, v, d, cur_en);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run_burst(input logic [W-1:0] seed, input int pc, input int bad_idx,
                            input logic [W-1:0] bad_val, input int maxgap);
      logic [W-1:0] d;
      cur_seed = seed; cur_pc = pc; cur_en = 1'b0;
      step(1'b1, 1'b0, '0);
      for (int i = 0; i <= pc; i++) begin
         int g;
         g = $urandom_range(0, maxgap);
         repeat (g) step(1'b0, 1'b0, '0);
         d = seed + W'(i);
         if (i == bad_idx) d = bad_val;
         step(1'b0, 1'b1, d);
      end
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [63:0]  r;
      logic [W-1:0] s, d;
      rst_n = 1'b0; chk_start = 1'b0; seed_in = '0; patgen_cnt = '0;
      cntuspatt_en = 1'b0; data_vld = 1'b0; data_in = '0;
      cur_seed = '0; cur_pc = 0; cur_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Clean burst of 8 words.
      run_burst(40'h10, 7, -1, '0, 2);
      chk_val("s1_pass", 64'(chk_pass), 64'd1);
      chk_val("s1_rcv",  64'(rcv_cnt),  64'd8);

      // Word 3 corrupted; expected sequence continues.
      run_burst(40'h10, 7, 3, 40'hDEAD, 1);
      chk_val("s2_err",   64'(err_cnt),       64'd1);
      chk_val("s2_first", 64'(first_err_idx), 64'd3);
      chk_val("s2_pass",  64'(chk_pass),      64'd0);

      // Expected word wraps through zero.
      run_burst(40'hFF_FFFF_FFFE, 3, -1, '0, 1);
      chk_val("s3_pass", 64'(chk_pass), 64'd1);

      // Single-word burst.
      run_burst(40'h55, 0, -1, '0, 0);
      chk_val("s3b_rcv", 64'(rcv_cnt), 64'd1);

      // Randomized bursts with occasional corrupted word.
      for (int k = 0; k < 8; k++) begin
         int pc, bad;
         r = {$urandom, $urandom};
         s = r[W-1:0];
         pc = $urandom_range(0, 20);
         bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, pc)) : -1;
         run_burst(s, pc, bad, ~(s + W'(bad)), 3);
      end

      // Continuous mode: 300 words with gaps, then drop the enable.
      cur_seed = 40'h12_3456_7890; cur_pc = 5; cur_en = 1'b1;
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 300; i++) begin
         int g;
         g = $urandom_range(0, 3);
         repeat (g) step(1'b0, 1'b0, '0);
         d = cur_seed + W'(i);
         step(1'b0, 1'b1, d);
      end
      cur_en = 1'b0;
      step(1'b0, 1'b0, '0);
      chk_val("s4_done", 64'(chk_done), 64'd1);
      chk_val("s4_rcv",  64'(rcv_cnt),  64'd300);
      chk_val("s4_pass", 64'(chk_pass), 64'd1);

      // Watchdog expiry after 2 of 8 words, then a stray word in DONE.
      cur_seed = 40'h200; cur_pc = 7; cur_en = 1'b0;
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 40'h200);
      step(1'b0, 1'b1, 40'h201);
      repeat (20) step(1'b0, 1'b0, '0);
      chk_val("s5_timeout", 64'(timeout),  64'd1);
      chk_val("s5_pass",    64'(chk_pass), 64'd0);
      step(1'b0, 1'b1, 40'h202);
      chk_val("s5_overrun", 64'(overrun), 64'd1);

      // Start collides with a valid word, then reset mid-run.
      cur_seed = 40'h64;
      step(1'b1, 1'b1, 40'h64);
      chk_val("s6_rcv0", 64'(rcv_cnt), 64'd0);
      step(1'b0, 1'b1, 40'h64);
      step(1'b0, 1'b1, 40'h99);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 40'h1);
      step(1'b0, 1'b0, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
